wb_rr_arbiter2: RTL



---
 rtl/wb_arb_pkg.sv | 16 +
 rtl/wb_bus_watchdog.sv | 51 +++++
 rtl/wb_rr_arbiter2.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/wb_arb_pkg.sv
// Shared definitions for the two-master Wishbone round-robin arbiter and its bus watchdog.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StOwn0 = 2'd1,
    StOwn1 = 2'd2
  } arb_state_e;

  localparam logic [1:0] GrantNone = 2'b00;
  localparam logic [1:0] GrantM0   = 2'b01;
  localparam logic [1:0] GrantM1   = 2'b10;

  localparam int unsigned DefaultTimeoutCycles = 255;

endpackage

// File: rtl/wb_bus_watchdog.sv
// Bus watchdog: counts stalled strobe cycles and raises a one-cycle forced error
// once a slave has failed to respond for TIMEOUT_CYCLES cycles.
module wb_bus_watchdog
  import wb_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles,
  parameter int unsigned CNT_W          = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic stb_i,
  input  logic ack_i,
  input  logic err_i,
  input  logic clear_i,
  output logic force_err_o
);

  localparam bit               Enabled = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] Limit   = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             force_q, force_d;
  logic             stall;

  always_comb begin
    stall   = stb_i & ~ack_i & ~err_i;
    count_d = '0;
    force_d = 1'b0;
    // Any response, idle strobe or owner change leaves the count at zero.
    if (Enabled && stall && !clear_i) begin
      if (count_q == Limit) begin
        force_d = 1'b1;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
      force_q <= 1'b0;
    end else begin
      count_q <= count_d;
      force_q <= force_d;
    end
  end

  assign force_err_o = force_q;

endmodule

// File: rtl/wb_rr_arbiter2.sv
// Two-master Wishbone classic arbiter: round-robin on contention, grant held for
// the owner's whole cycle, watchdog turns a hung slave into a one-cycle error.
module wb_rr_arbiter2
  import wb_arb_pkg::*;
#(
  parameter int unsigned AW             = 32,
  parameter int unsigned DW             = 32,
  parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles,
  parameter int unsigned CNT_W          = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic            m0_we_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic            m1_we_i,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic            s_we_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  output logic [1:0]      grant_o
);

  arb_state_e state_q, state_d;
  logic       last_owner_q, last_owner_d;  // 0: m0 owned last, 1: m1 owned last
  logic       force_err;
  logic       owner_change;

  // Next-state: registered arbitration from idle, same-cycle re-arbitration on release.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    unique case (state_q)
      StIdle: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_d = last_owner_q ? StOwn0 : StOwn1;
        end else if (m0_cyc_i) begin
          state_d = StOwn0;
        end else if (m1_cyc_i) begin
          state_d = StOwn1;
        end
      end
      StOwn0: begin
        if (!m0_cyc_i) begin
          last_owner_d = 1'b0;
          state_d      = m1_cyc_i ? StOwn1 : StIdle;
        end
      end
      StOwn1: begin
        if (!m1_cyc_i) begin
          last_owner_d = 1'b1;
          state_d      = m0_cyc_i ? StOwn0 : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      last_owner_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
    end
  end

  assign owner_change = (state_d != state_q);

  // Bus mux; during a forced error the strobe is withheld and a late ack is dropped.
  always_comb begin
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    s_we_o   = 1'b0;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    grant_o  = GrantNone;
    unique case (state_q)
      StOwn0: begin
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        s_we_o   = m0_we_i;
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i & ~force_err;
        m0_ack_o = s_ack_i & ~force_err;
        m0_err_o = s_err_i | force_err;
        grant_o  = GrantM0;
      end
      StOwn1: begin
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        s_we_o   = m1_we_i;
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i & ~force_err;
        m1_ack_o = s_ack_i & ~force_err;
        m1_err_o = s_err_i | force_err;
        grant_o  = GrantM1;
      end
      default: ;
    endcase
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  wb_bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_watchdog (
    .clock      (clock),
    .reset      (reset),
    .stb_i      (s_stb_o),
    .ack_i      (s_ack_i),
    .err_i      (s_err_i),
    .clear_i    (owner_change),
    .force_err_o(force_err)
  );

endmodule
